// File: rtl/router_register_pkg.sv
// Shared router definitions: header field layout and the reserved address.
package router_register_pkg;

  localparam int BYTE_W = 8;
  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;

  // Address value reserved as "no destination"; headers carrying it are ignored.
  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

  typedef logic [BYTE_W-1:0] byte_t;

  // Header layout: {payload_len, addr}.
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } header_t;

  function automatic logic addr_ok(input byte_t b);
    header_t h;
    h = header_t'(b);
    return h.addr != INVALID_ADDR;
  endfunction

endpackage

// File: rtl/router_register.sv
// Router datapath register: latches the header, forwards bytes to the
// destination FIFO, buffers a byte across a FIFO-full stall, and checks
// the trailing parity byte against the running XOR of header and payload.
module router_register
  import router_register_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              rst_int_reg,
  input  logic              detect_add,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              lfd_state,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic [BYTE_W-1:0] dout
);

  byte_t header_byte;
  byte_t full_state_byte;
  byte_t internal_parity;
  byte_t packet_parity;

  logic cap_ld;
  logic cap_laf;
  logic cap;

  // Parity byte is seen either directly in LOAD_DATA (pkt_valid dropped with
  // room in the FIFO) or replayed from the stall buffer in LOAD_AFTER_FULL.
  always_comb begin
    cap_ld  = ld_state && !fifo_full && !pkt_valid;
    cap_laf = laf_state && low_pkt_valid && !parity_done;
    cap     = cap_ld || cap_laf;
  end

  // Header latch and FIFO-full holding byte.
  always_ff @(posedge clock) begin
    if (!reset) begin
      header_byte     <= '0;
      full_state_byte <= '0;
    end else begin
      if (detect_add && pkt_valid && addr_ok(data_in))
        header_byte <= data_in;
      if (ld_state && fifo_full)
        full_state_byte <= data_in;
    end
  end

  // Output byte to the FIFO: header first, then live data, then the stalled byte.
  always_ff @(posedge clock) begin
    if (!reset)
      dout <= '0;
    else if (lfd_state)
      dout <= header_byte;
    else if (ld_state && !fifo_full)
      dout <= data_in;
    else if (laf_state)
      dout <= full_state_byte;
  end

  // low_pkt_valid remembers that the packet body ended while loading.
  always_ff @(posedge clock) begin
    if (!reset)
      low_pkt_valid <= 1'b0;
    else if (rst_int_reg)
      low_pkt_valid <= 1'b0;
    else if (ld_state && !pkt_valid)
      low_pkt_valid <= 1'b1;
  end

  // Parity capture: a new header restarts both parity registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      parity_done   <= 1'b0;
      packet_parity <= '0;
    end else if (detect_add) begin
      parity_done   <= 1'b0;
      packet_parity <= '0;
    end else if (cap) begin
      parity_done   <= 1'b1;
      packet_parity <= cap_ld ? data_in : full_state_byte;
    end
  end

  // Running XOR over the header and every payload byte accepted in LOAD_DATA.
  always_ff @(posedge clock) begin
    if (!reset)
      internal_parity <= '0;
    else if (detect_add)
      internal_parity <= '0;
    else if (lfd_state)
      internal_parity <= internal_parity ^ header_byte;
    else if (ld_state && pkt_valid && !full_state)
      internal_parity <= internal_parity ^ data_in;
  end

  // Error compares once parity_done is registered, so err trails it by a cycle.
  always_ff @(posedge clock) begin
    if (!reset)
      err <= 1'b0;
    else if (detect_add)
      err <= 1'b0;
    else if (parity_done)
      err <= (internal_parity != packet_parity);
  end

endmodule

// File: tb/tb_router_register.sv
module tb_router_register;

  logic       clock;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       rst_int_reg;
  logic       detect_add;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       lfd_state;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;
  logic [7:0] dout;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  router_register dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .lfd_state(lfd_state), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .err(err), .dout(dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packet-level model: tracks what the router has seen of the current
  // packet (header, stalled byte, accumulated XOR, received parity).
  logic [7:0] m_hdr, m_stall, m_xor, m_rxpar, m_dout;
  logic       m_body_end, m_par_seen, m_err;

  always @(posedge clock) begin
    logic [7:0] n_hdr, n_stall, n_xor, n_rxpar, n_dout;
    logic       n_body_end, n_par_seen, n_err;
    logic       parity_live, parity_replay;
    if (!reset) begin
      {m_hdr, m_stall, m_xor, m_rxpar, m_dout} = '0;
      {m_body_end, m_par_seen, m_err} = '0;
    end else begin
      n_hdr = m_hdr; n_stall = m_stall; n_xor = m_xor; n_rxpar = m_rxpar;
      n_dout = m_dout; n_body_end = m_body_end; n_par_seen = m_par_seen; n_err = m_err;
      parity_live   = ld_state && !fifo_full && !pkt_valid;
      parity_replay = laf_state && m_body_end && !m_par_seen;
      if (detect_add && pkt_valid && (data_in % 4) != 3) n_hdr = data_in;
      if (ld_state && fifo_full) n_stall = data_in;
      case (1'b1)
        lfd_state:                n_dout = m_hdr;
        (ld_state && !fifo_full): n_dout = data_in;
        laf_state:                n_dout = m_stall;
        default: ;
      endcase
      if (rst_int_reg) n_body_end = 0;
      else if (ld_state && !pkt_valid) n_body_end = 1;
      if (detect_add) begin
        n_par_seen = 0; n_rxpar = 0; n_xor = 0; n_err = 0;
      end else begin
        if (parity_live)        begin n_par_seen = 1; n_rxpar = data_in; end
        else if (parity_replay) begin n_par_seen = 1; n_rxpar = m_stall; end
        if (lfd_state) n_xor = m_xor ^ m_hdr;
        else if (ld_state && pkt_valid && !full_state) n_xor = m_xor ^ data_in;
        if (m_par_seen) n_err = (m_xor != m_rxpar);
      end
      m_hdr = n_hdr; m_stall = n_stall; m_xor = n_xor; m_rxpar = n_rxpar;
      m_dout = n_dout; m_body_end = n_body_end; m_par_seen = n_par_seen; m_err = n_err;
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      n_tests++;
      if (dout !== m_dout || parity_done !== m_par_seen ||
          low_pkt_valid !== m_body_end || err !== m_err) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got dout=%h pd=%b lpv=%b err=%b want dout=%h pd=%b lpv=%b err=%b",
                 $time, dout, parity_done, low_pkt_valid, err,
                 m_dout, m_par_seen, m_body_end, m_err);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Apply one cycle of inputs; returns 1 time unit after the rising edge.
  task automatic drive(input logic rst, input logic pv, input logic [7:0] d,
                       input logic ff, input logic rir, input logic da,
                       input logic ld, input logic laf, input logic fs,
                       input logic lfd);
    reset = rst; pkt_valid = pv; data_in = d; fifo_full = ff; rst_int_reg = rir;
    detect_add = da; ld_state = ld; laf_state = laf; full_state = fs; lfd_state = lfd;
    @(posedge clock);
    #1;
  endtask

  // Shorthands: argument order rst,pv,d,ff,rir,da,ld,laf,fs,lfd
  task automatic idle();                          drive(1,0,8'h00,0,0,0,0,0,0,0); endtask
  task automatic hdr(input logic [7:0] d);        drive(1,1,d,    0,0,1,0,0,0,0); endtask
  task automatic lfd();                           drive(1,1,8'h00,0,0,0,0,0,0,1); endtask
  task automatic ld(input logic pv, input logic [7:0] d, input logic ff);
                                                  drive(1,pv,d,   ff,0,0,1,0,0,0); endtask
  task automatic laf();                           drive(1,0,8'h00,0,0,0,0,1,0,0); endtask

  initial begin
    // Reset
    drive(0,1,8'hFF,1,0,1,1,1,0,1);
    chk_en = 1;
    check("rst_dout", dout, 8'h00);
    check("rst_pd",   {7'b0, parity_done}, 8'h00);
    check("rst_lpv",  {7'b0, low_pkt_valid}, 8'h00);
    check("rst_err",  {7'b0, err}, 8'h00);

    // Good packet: 06 ^ 5A = 5C
    hdr(8'h06);
    lfd();             check("good_hdr_out", dout, 8'h06);
    ld(1, 8'h5A, 0);   check("good_payload", dout, 8'h5A);
    ld(0, 8'h5C, 0);   check("good_parity_out", dout, 8'h5C);
                       check("good_pd",  {7'b0, parity_done}, 8'h01);
                       check("good_lpv", {7'b0, low_pkt_valid}, 8'h01);
    drive(1,0,8'h00,0,1,0,0,0,0,0);
                       check("good_err", {7'b0, err}, 8'h00);
                       check("rir_clear", {7'b0, low_pkt_valid}, 8'h00);

    // Bad parity byte
    hdr(8'h06);        check("hdr_clears_pd", {7'b0, parity_done}, 8'h00);
    lfd();
    ld(1, 8'h5A, 0);
    ld(0, 8'h00, 0);   check("bad_pd", {7'b0, parity_done}, 8'h01);
                       check("bad_err_not_yet", {7'b0, err}, 8'h00);
    idle();            check("bad_err", {7'b0, err}, 8'h01);
    hdr(8'h06);        check("bad_err_clr", {7'b0, err}, 8'h00);
                       check("bad_pd_clr", {7'b0, parity_done}, 8'h00);

    // Invalid address headers are ignored
    hdr(8'h07);
    lfd();             check("inv_addr_06", dout, 8'h06);
    hdr(8'h09);
    hdr(8'h0B);
    lfd();             check("inv_addr_09", dout, 8'h09);

    // FIFO full stall, then replay
    ld(1, 8'h33, 1);   check("full_hold", dout, 8'h09);
    laf();             check("laf_replay", dout, 8'h33);

    // rst_int_reg beats set condition
    ld(0, 8'h11, 0);   check("lpv_set", {7'b0, low_pkt_valid}, 8'h01);
    drive(1,0,8'h22,0,1,0,1,0,0,0);
                       check("rir_priority", {7'b0, low_pkt_valid}, 8'h00);

    // Parity byte arriving while FIFO full, captured via LOAD_AFTER_FULL
    drive(1,0,8'h00,0,1,0,0,0,0,0);
    hdr(8'h06);
    lfd();
    ld(1, 8'h5A, 1);
    laf();             check("laf_payload", dout, 8'h5A);
    ld(0, 8'h5C, 1);   check("laf_no_cap", {7'b0, parity_done}, 8'h00);
    laf();             check("laf_cap_pd", {7'b0, parity_done}, 8'h01);
                       check("laf_cap_out", dout, 8'h5C);
    idle();            check("laf_err", {7'b0, err}, 8'h00);

    // Mid-packet reset
    hdr(8'h0D);
    lfd();
    drive(0,1,8'hAA,0,0,0,1,0,0,0);
                       check("mid_rst_dout", dout, 8'h00);
    lfd();             check("mid_rst_hdr", dout, 8'h00);
    idle();
    idle();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_register.md
ROUTER_REGISTER -- requirements
Module: router_register

Interface
REQ-001 Clocking and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 pkt_valid  input  1  high while header/payload bytes are on data_in; low on the parity byte.
REQ-005 data_in  input  8  packet byte stream; header = {payload_len[5:0], addr[1:0]}.
REQ-006 fifo_full  input  1  selected destination FIFO is full.
REQ-007 rst_int_reg  input  1  FSM request to clear low_pkt_valid.
REQ-008 detect_add, ld_state, laf_state, full_state, lfd_state  input  1 each  FSM state decodes (DECODE_ADDRESS, LOAD_DATA, LOAD_AFTER_FULL, FIFO_FULL_STATE, LOAD_FIRST_DATA).
REQ-009 parity_done  output  1  packet parity byte captured.
REQ-010 low_pkt_valid  output  1  pkt_valid fell during LOAD_DATA.
REQ-011 err  output  1  parity mismatch flag.
REQ-012 dout  output  8  registered byte to FIFO.
REQ-013 Port order SHALL be clock, reset, pkt_valid, data_in, fifo_full, rst_int_reg, detect_add, ld_state, laf_state, full_state, lfd_state, parity_done, low_pkt_valid, err, dout.

Function
REQ-014 All outputs and internal registers (header_byte, full_state_byte, internal_parity, packet_parity) SHALL update only on rising clock.
REQ-015 header_byte SHALL load data_in when detect_add && pkt_valid && data_in[1:0] != 2'b11; otherwise hold.
REQ-016 dout SHALL load, in priority order: lfd_state -> header_byte; ld_state && !fifo_full -> data_in; laf_state -> full_state_byte; else hold.
REQ-017 full_state_byte SHALL load data_in when ld_state && fifo_full; dout holds that cycle.
REQ-018 low_pkt_valid SHALL clear on rst_int_reg (priority), set on ld_state && !pkt_valid, else hold.
REQ-019 Capture condition CAP = (ld_state && !fifo_full && !pkt_valid) || (laf_state && low_pkt_valid && !parity_done).
REQ-020 parity_done SHALL clear on detect_add (priority), set on CAP, else hold.
REQ-021 packet_parity SHALL clear on detect_add; on CAP load data_in (ld case) or full_state_byte (laf case); else hold.
REQ-022 internal_parity SHALL clear on detect_add; on lfd_state XOR with header_byte; on ld_state && pkt_valid && !full_state XOR with data_in; else hold.
REQ-023 err SHALL clear on detect_add; when parity_done=1 load (internal_parity != packet_parity); else hold; err is valid one cycle after parity_done rises.
REQ-024 Latency: a byte presented with ld_state (not full) SHALL appear on dout after one clock; header appears one clock after lfd_state.
REQ-025 Address 2'b11 headers SHALL leave header_byte unchanged.

Reset
REQ-026 On reset=0 at a rising edge: dout=8'h00, parity_done=0, low_pkt_valid=0, err=0, all internal registers 0; reset overrides every other input, including mid-packet.

Structure
REQ-027 Invalid-address constant (2'b11) and header field widths SHALL live in the shared router package.
REQ-028 Single flat module; no sub-modules.

Verification
REQ-029 Reset: drive reset=0 one cycle -> dout=00, parity_done=0, low_pkt_valid=0, err=0.
REQ-030 Good packet: header 8'h06 with detect_add, lfd_state, payload 8'h5A (ld_state, pkt_valid=1), parity 8'h5C (pkt_valid=0) -> dout 06, 5A, 5C; parity_done=1 and low_pkt_valid=1 after parity byte; err=0 next cycle.
REQ-031 Bad parity: same packet with parity byte 8'h00 -> parity_done=1, err=1 one cycle later; next detect_add clears err and parity_done.
REQ-032 FIFO full: ld_state, fifo_full=1, data_in=8'h33 -> dout unchanged; then laf_state -> dout=33.
REQ-033 Invalid address: detect_add, pkt_valid, data_in=8'h07 after a valid 8'h06 header -> lfd_state yields dout=06.
REQ-034 rst_int_reg=1 with low_pkt_valid=1 -> low_pkt_valid=0 next cycle, even if ld_state && !pkt_valid.
